// File: rtl/frame_rd_arbiter_pkg.sv
// Shared constants and encodings for the frame-memory port-B read arbiter.
package frame_rd_arbiter_pkg;

  localparam int H_IMG_RES = 640;
  localparam int V_IMG_RES = 480;
  localparam int ADDR_W    = 19;
  localparam int FRAME_PIX = H_IMG_RES * V_IMG_RES;

  typedef enum logic [1:0] {
    DISP  = 2'd0,
    BLANK = 2'd1,
    SCAN  = 2'd2
  } arb_state_e;

  localparam logic TAG_DISP = 1'b0;
  localparam logic TAG_SCAN = 1'b1;

  // Raster position to linear frame-memory address.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [10:0] h, input logic [10:0] v);
    return ADDR_W'(32'(H_IMG_RES) * 32'(v) + 32'(h));
  endfunction

endpackage

// File: rtl/frame_rd_arbiter_rd_tag_pipe.sv
// Valid + owner-tag shift register that tracks reads through the memory latency.
module rd_tag_pipe
  import frame_rd_arbiter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic vld_i,
  input  logic tag_i,
  output logic vld_o,
  output logic tag_o
);

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] tag_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      tag_q <= {DEPTH{TAG_DISP}};
    end else begin
      vld_q[0] <= vld_i;
      tag_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign vld_o = vld_q[DEPTH-1];
  assign tag_o = tag_q[DEPTH-1];

endmodule

// File: rtl/frame_rd_arbiter.sv
// Port-B owner for the foreground-mask frame memory: display has priority in the
// active area, the blob scanner gets single-beat reads in blanking.
module frame_rd_arbiter
  import frame_rd_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              app_clk,
  input  logic              app_rst,
  input  logic [10:0]       vid_hpos,
  input  logic [10:0]       vid_vpos,
  output logic [ADDR_W-1:0] ram_addrb,
  input  logic              ram_doutb,
  output logic              disp_px,
  output logic              disp_px_valid,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic              scan_gnt,
  output logic              scan_err,
  output logic              scan_rdata,
  output logic              scan_rvalid,
  output logic              frame_start,
  output logic [15:0]       scan_beats,
  output logic              scan_overrun
);

  localparam logic [10:0]       H_LIM    = 11'(H_IMG_RES);
  localparam logic [10:0]       V_LIM    = 11'(V_IMG_RES);
  localparam logic [ADDR_W-1:0] ADDR_LIM = ADDR_W'(FRAME_PIX);

  arb_state_e state_q;

  logic active;
  logic scan_phase;
  logic addr_ok;
  logic gnt;
  logic err;
  logic pipe_vld;
  logic pipe_tag;

  logic        disp_px_q;
  logic        disp_px_valid_q;
  logic        scan_rdata_q;
  logic        scan_rvalid_q;
  logic        frame_start_q;
  logic [15:0] scan_beats_q;
  logic        scan_overrun_q;
  logic [15:0] beat_cnt_q;
  logic [15:0] beat_cnt_d;

  assign active     = (vid_hpos < H_LIM) && (vid_vpos < V_LIM);
  // A scan beat can only be issued once the FSM has already left DISP, so a
  // beat is never cut short by the display taking the port back.
  assign scan_phase = (state_q != DISP) && !active;
  assign addr_ok    = scan_addr < ADDR_LIM;
  assign gnt        = scan_phase && scan_req && addr_ok;
  assign err        = scan_phase && scan_req && !addr_ok;

  assign scan_gnt = gnt;
  assign scan_err = err;

  always_comb begin
    ram_addrb = '0;
    if (active) begin
      ram_addrb = pix_addr(vid_hpos, vid_vpos);
    end else if (gnt) begin
      ram_addrb = scan_addr;
    end
  end

  always_ff @(posedge app_clk or posedge app_rst) begin
    if (app_rst) begin
      state_q <= DISP;
    end else begin
      unique case (state_q)
        DISP: begin
          if (!active) state_q <= BLANK;
        end
        BLANK: begin
          if (active)   state_q <= DISP;
          else if (gnt) state_q <= SCAN;
        end
        SCAN: begin
          if (active)         state_q <= DISP;
          else if (!scan_req) state_q <= BLANK;
        end
        default: state_q <= DISP;
      endcase
    end
  end

  rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag_pipe (
    .clk_i (app_clk),
    .rst_i (app_rst),
    .vld_i (active || gnt),
    .tag_i (gnt ? TAG_SCAN : TAG_DISP),
    .vld_o (pipe_vld),
    .tag_o (pipe_tag)
  );

  always_ff @(posedge app_clk or posedge app_rst) begin
    if (app_rst) begin
      disp_px_q       <= 1'b0;
      disp_px_valid_q <= 1'b0;
      scan_rdata_q    <= 1'b0;
      scan_rvalid_q   <= 1'b0;
    end else begin
      disp_px_q       <= pipe_vld && (pipe_tag == TAG_DISP) && ram_doutb;
      disp_px_valid_q <= pipe_vld && (pipe_tag == TAG_DISP);
      scan_rvalid_q   <= pipe_vld && (pipe_tag == TAG_SCAN);
      if (pipe_vld && (pipe_tag == TAG_SCAN)) scan_rdata_q <= ram_doutb;
    end
  end

  // Beat counter restarts on the frame_start pulse, counting a grant in that cycle.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (frame_start_q) begin
      beat_cnt_d = gnt ? 16'd1 : 16'd0;
    end else if (gnt && (beat_cnt_q != 16'hFFFF)) begin
      beat_cnt_d = beat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge app_clk or posedge app_rst) begin
    if (app_rst) begin
      frame_start_q  <= 1'b0;
      scan_beats_q   <= 16'd0;
      scan_overrun_q <= 1'b0;
      beat_cnt_q     <= 16'd0;
    end else begin
      frame_start_q <= (vid_hpos == 11'd0) && (vid_vpos == 11'd0);
      beat_cnt_q    <= beat_cnt_d;
      if (frame_start_q) begin
        scan_beats_q   <= beat_cnt_q;
        scan_overrun_q <= scan_req;
      end
    end
  end

  assign disp_px       = disp_px_q;
  assign disp_px_valid = disp_px_valid_q;
  assign scan_rdata    = scan_rdata_q;
  assign scan_rvalid   = scan_rvalid_q;
  assign frame_start   = frame_start_q;
  assign scan_beats    = scan_beats_q;
  assign scan_overrun  = scan_overrun_q;

endmodule

// File: tb/tb_frame_rd_arbiter.sv
// Directed bench for frame_rd_arbiter with a scoreboard of expected read returns.
module tb_frame_rd_arbiter;
  import frame_rd_arbiter_pkg::*;

  localparam int RD_LAT = 1;

  logic        app_clk = 1'b0;
  logic        app_rst = 1'b1;
  logic [10:0] vid_hpos = 11'd700;
  logic [10:0] vid_vpos = 11'd500;
  logic [18:0] ram_addrb;
  logic        ram_doutb;
  logic        disp_px, disp_px_valid;
  logic        scan_req = 1'b0;
  logic [18:0] scan_addr = '0;
  logic        scan_gnt, scan_err, scan_rdata, scan_rvalid, frame_start;
  logic [15:0] scan_beats;
  logic        scan_overrun;

  typedef struct {
    int due;
    bit is_scan;
    bit data;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   last_sd = 1'b0;
  bit   fs_exp = 1'b0;

  frame_rd_arbiter #(.RD_LAT(RD_LAT)) dut (
    .app_clk       (app_clk),
    .app_rst       (app_rst),
    .vid_hpos      (vid_hpos),
    .vid_vpos      (vid_vpos),
    .ram_addrb     (ram_addrb),
    .ram_doutb     (ram_doutb),
    .disp_px       (disp_px),
    .disp_px_valid (disp_px_valid),
    .scan_req      (scan_req),
    .scan_addr     (scan_addr),
    .scan_gnt      (scan_gnt),
    .scan_err      (scan_err),
    .scan_rdata    (scan_rdata),
    .scan_rvalid   (scan_rvalid),
    .frame_start   (frame_start),
    .scan_beats    (scan_beats),
    .scan_overrun  (scan_overrun)
  );

  always #5 app_clk = ~app_clk;

  // Memory model: each location holds the low bit of its own address.
  always @(posedge app_clk) ram_doutb <= ram_addrb[0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_ret();
    bit ev_d = 1'b0;
    bit ev_s = 1'b0;
    bit ed = 1'b0;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      exp_t e = sbq.pop_front();
      if (e.is_scan) begin
        ev_s = 1'b1;
        last_sd = e.data;
      end else begin
        ev_d = 1'b1;
        ed = e.data;
      end
    end
    chk("disp_px_valid", disp_px_valid, ev_d);
    chk("disp_px", disp_px, ed);
    chk("scan_rvalid", scan_rvalid, ev_s);
    chk("scan_rdata", scan_rdata, last_sd);
    chk("frame_start", frame_start, fs_exp);
  endtask

  task automatic step(input int h, input int v, input bit req, input int addr,
                      input bit eg, input bit ee);
    bit act;
    @(negedge app_clk);
    check_ret();
    vid_hpos  = 11'(h);
    vid_vpos  = 11'(v);
    scan_req  = req;
    scan_addr = 19'(addr);
    #1;
    act = (h < 640) && (v < 480);
    chk("scan_gnt", scan_gnt, eg);
    chk("scan_err", scan_err, ee);
    if (act) begin
      chk("ram_addrb_disp", ram_addrb, 640 * v + h);
      sbq.push_back('{due: cyc + RD_LAT + 1, is_scan: 1'b0, data: 1'((640 * v + h) & 1)});
    end else if (eg) begin
      chk("ram_addrb_scan", ram_addrb, addr);
      sbq.push_back('{due: cyc + RD_LAT + 1, is_scan: 1'b1, data: 1'(addr & 1)});
    end
    fs_exp = (h == 0) && (v == 0);
    cyc++;
  endtask

  task automatic rst_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge app_clk);
      app_rst  = 1'b1;
      scan_req = 1'b0;
      vid_hpos = 11'd700;
      vid_vpos = 11'd500;
      #1;
      sbq.delete();
      last_sd = 1'b0;
      fs_exp  = 1'b0;
      chk("rst_disp_px", disp_px, 0);
      chk("rst_disp_px_valid", disp_px_valid, 0);
      chk("rst_scan_rvalid", scan_rvalid, 0);
      chk("rst_scan_rdata", scan_rdata, 0);
      chk("rst_frame_start", frame_start, 0);
      chk("rst_scan_beats", scan_beats, 0);
      chk("rst_scan_overrun", scan_overrun, 0);
      chk("rst_scan_gnt", scan_gnt, 0);
      chk("rst_scan_err", scan_err, 0);
      cyc++;
    end
    app_rst = 1'b0;
  endtask

  initial begin
    int vlist[4];
    vlist = '{0, 1, 479, 480};
    rst_cycles(3);

    // Display path over a few full lines, including the first and last active rows.
    foreach (vlist[k]) begin
      for (int h = 0; h < 800; h++) step(h, vlist[k], 1'b0, 0, 1'b0, 1'b0);
    end

    // Blanking burst of back-to-back scan beats.
    step(640, 10, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(640, 10, 1'b1, 100 + i, 1'b1, 1'b0);
    step(641, 10, 1'b0, 0, 1'b0, 1'b0);

    // Collision: request raised during active pixels waits for blanking.
    for (int h = 0; h < 10; h++) step(h, 20, 1'b1, 200, 1'b0, 1'b0);
    step(640, 20, 1'b1, 200, 1'b0, 1'b0);
    step(641, 20, 1'b1, 200, 1'b1, 1'b0);
    step(642, 20, 1'b0, 0, 1'b0, 1'b0);
    step(643, 20, 1'b1, 201, 1'b1, 1'b0);
    step(0, 21, 1'b1, 202, 1'b0, 1'b0);
    step(1, 21, 1'b0, 0, 1'b0, 1'b0);

    // Address range boundary.
    step(640, 30, 1'b0, 0, 1'b0, 1'b0);
    step(640, 30, 1'b1, 307200, 1'b0, 1'b1);
    step(641, 30, 1'b1, 524287, 1'b0, 1'b1);
    step(642, 30, 1'b1, 307199, 1'b1, 1'b0);
    step(643, 30, 1'b0, 0, 1'b0, 1'b0);

    // Frame statistics and overrun flag.
    step(0, 0, 1'b0, 0, 1'b0, 1'b0);
    step(1, 0, 1'b0, 0, 1'b0, 1'b0);
    step(640, 0, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(640, 0, 1'b1, 10 + i, 1'b1, 1'b0);
    step(641, 0, 1'b0, 0, 1'b0, 1'b0);
    step(0, 0, 1'b1, 20, 1'b0, 1'b0);
    step(1, 0, 1'b1, 20, 1'b0, 1'b0);
    step(2, 0, 1'b0, 0, 1'b0, 1'b0);
    chk("scan_beats_n", scan_beats, 5);
    chk("scan_overrun_set", scan_overrun, 1);
    step(3, 0, 1'b0, 0, 1'b0, 1'b0);
    chk("scan_overrun_sticky", scan_overrun, 1);
    step(0, 0, 1'b0, 0, 1'b0, 1'b0);
    step(1, 0, 1'b0, 0, 1'b0, 1'b0);
    step(2, 0, 1'b0, 0, 1'b0, 1'b0);
    chk("scan_beats_n1", scan_beats, 0);
    chk("scan_overrun_clr", scan_overrun, 0);

    // Reset in the cycle after a grant discards the in-flight beat.
    step(640, 40, 1'b0, 0, 1'b0, 1'b0);
    step(640, 40, 1'b1, 301, 1'b1, 1'b0);
    rst_cycles(2);
    for (int i = 0; i < 3; i++) step(640, 40, 1'b0, 0, 1'b0, 1'b0);
    step(640, 40, 1'b1, 305, 1'b1, 1'b0);
    step(641, 40, 1'b1, 306, 1'b1, 1'b0);
    step(642, 40, 1'b0, 0, 1'b0, 1'b0);
    for (int h = 0; h < 6; h++) step(h, 41, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(700, 41, 1'b0, 0, 1'b0, 1'b0);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_rd_arbiter.md
Name: frame_rd_arbiter

Overview:
- Owns read port B of the binary frame memory that stores the filtered foreground mask.
- Shares that port between two requesters: the video display path, which has absolute priority during active pixels, and a blob-scan engine, which gets single-beat reads only in blanking.
- Tags each returned read with its owner and generates frame-boundary strobes.
- Keeps per-frame scan statistics, including beat count and overrun/error flags.

Parameters:
- H_IMG_RES, 640, active pixels per line.
- V_IMG_RES, 480, active lines per frame.
- ADDR_W, 19, frame memory address width.
- RD_LAT, 1, frame memory read latency in cycles (range 1..3).

Ports:
- app_clk  in  1  pixel/application clock.
- app_rst  in  1  asynchronous active-high reset.
- vid_hpos  in  11  current horizontal position.
- vid_vpos  in  11  current vertical position.
- ram_addrb  out  ADDR_W  frame memory port B address.
- ram_doutb  in  1  frame memory port B data, valid RD_LAT cycles after the address.
- disp_px  out  1  display pixel.
- disp_px_valid  out  1  disp_px corresponds to an active-area read.
- scan_req  in  1  scan engine requests one read; held until granted.
- scan_addr  in  ADDR_W  scan read address; stable while scan_req is high.
- scan_gnt  out  1  one-cycle pulse: scan address presented this cycle.
- scan_err  out  1  one-cycle pulse: scan_addr >= H_IMG_RES*V_IMG_RES, request dropped.
- scan_rdata  out  1  scan read data.
- scan_rvalid  out  1  scan_rdata valid.
- frame_start  out  1  pulse in the cycle hpos==0 && vpos==0.
- scan_beats  out  16  granted scan beats in the previous frame, saturating at 16'hFFFF.
- scan_overrun  out  1  sticky flag: scan_req was high at frame_start; cleared when the next frame_start sees scan_req low.

Behaviour:
- Reset (async): every output register is 0, the tag pipeline is empty, the beat counter is 0, and the FSM is in DISP.
- Active region: active = (vid_hpos < H_IMG_RES) && (vid_vpos < V_IMG_RES).
- Display owns the port whenever active is high.
  - ram_addrb = H_IMG_RES*vid_vpos + vid_hpos, combinational and sized to ADDR_W.
- FSM states and transitions:
  - DISP: active high. Go to BLANK when active is low.
  - BLANK: port idle. If scan_req is high, an in-range address and active is low, then present scan_addr, pulse scan_gnt and go to SCAN. If active rises, go to DISP.
  - SCAN: one beat per cycle while scan_req is high and active is low (back-to-back grants allowed). Go to BLANK if scan_req is low. Go to DISP if active rises; that same cycle the display wins and no grant is issued.
- Priority collision: if active and scan_req are high in the same cycle, the display wins. scan_gnt stays 0 and the scan request remains pending; the FSM never preempts a beat already presented.
- Out-of-range scan_addr in BLANK/SCAN: no grant, scan_err pulses for 1 cycle, and the FSM stays in its state. The requester must drop or change scan_req.
- Return path: a 1-bit owner tag plus valid bit per cycle goes through an RD_LAT-deep shift pipeline.
  - At pipeline exit, display-tagged data is registered into disp_px with disp_px_valid=1.
  - Scan-tagged data is registered into scan_rdata with scan_rvalid=1.
  - Total latency from address to output = RD_LAT+1 cycles.
  - Non-owner outputs: disp_px=0, disp_px_valid=0, scan_rvalid=0; scan_rdata holds its last value.
- Frame boundary: frame_start is registered from the hpos/vpos compare, so it pulses 1 cycle after hpos==0 && vpos==0.
  - In that cycle scan_beats <= beat counter, and the counter clears to 0, or to 1 if a grant happens in the same cycle.
  - scan_overrun updates as defined above.
- Reset mid-operation: in-flight beats are discarded and no rvalid is emitted for them.

Decomposition:
- Shared package/include holds H_IMG_RES, V_IMG_RES, ADDR_W, FSM state encodings (DISP=2'd0, BLANK=2'd1, SCAN=2'd2) and the owner tag encoding (TAG_DISP=0, TAG_SCAN=1).
- One sub-module is natural: rd_tag_pipe, the RD_LAT-deep valid+tag shift register with async reset.

Test Plan:
- Display path: reset release, sweep hpos 0..799, vpos 0..524, RAM model holding addr[0] as data → disp_px at position (h,v) equals bit (640*v+h)&1, arriving RD_LAT+1 cycles later; no scan_rvalid seen.
- Blanking burst: hpos=640, vpos=10, scan_req held 8 cycles with addresses 100..107 → 8 consecutive scan_gnt pulses; scan_rdata matches each address, arriving 2 cycles later with RD_LAT=1.
- Collision: scan_req rises at hpos=0, vpos=20 (active) → no scan_gnt until hpos=640; display data is uninterrupted.
- Range error: in blanking, scan_addr=307200 → scan_err for 1 cycle, scan_gnt=0, no scan_rvalid.
- Frame stats: 5 grants in frame N, then scan_req held high across hpos=0, vpos=0 → frame_start pulse, scan_beats=5, scan_overrun=1; the next frame_start with scan_req low clears it.
- Reset mid-beat: assert app_rst in the cycle after scan_gnt → scan_rvalid never asserts, all outputs 0; normal operation resumes after release.
